pipeline_top: RTL and testbench



---
 rtl/pipeline_top.sv | 88 ++++++++
 tb/tb_pipeline_top.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipeline_top.sv
// Three-stage pipelined ALU: fetch from internal instruction memory, decode the
// immediate fields, execute and register the result. The program loops forever.
module pipeline_top #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] opcode,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam int unsigned INSTR_W = 3 * WIDTH;

  localparam logic [WIDTH-1:0] OP_ADD  = WIDTH'(8'h00);
  localparam logic [WIDTH-1:0] OP_SUB  = WIDTH'(8'h01);
  localparam logic [WIDTH-1:0] OP_AND  = WIDTH'(8'h02);
  localparam logic [WIDTH-1:0] OP_OR   = WIDTH'(8'h03);
  localparam logic [WIDTH-1:0] OP_XOR  = WIDTH'(8'h04);
  localparam logic [WIDTH-1:0] OP_NOT  = WIDTH'(8'h05);
  localparam logic [WIDTH-1:0] OP_SHL  = WIDTH'(8'h06);
  localparam logic [WIDTH-1:0] OP_SHR  = WIDTH'(8'h07);
  localparam logic [WIDTH-1:0] OP_INC  = WIDTH'(8'h08);
  localparam logic [WIDTH-1:0] OP_DEC  = WIDTH'(8'h09);
  localparam logic [WIDTH-1:0] OP_PASS = WIDTH'(8'h0A);

  // Program store, loaded externally before execution; never reset or written here.
  logic [INSTR_W-1:0] instr_mem [0:DEPTH-1];

  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [WIDTH-1:0]   w_alu;

  // Stage 1: fetch; pc wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      r_ir <= instr_mem[r_pc];
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  // Stage 2: split the instruction word into opcode and immediate operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode <= '0;
      a      <= '0;
      b      <= '0;
    end else begin
      opcode <= r_ir[3*WIDTH-1:2*WIDTH];
      a      <= r_ir[2*WIDTH-1:WIDTH];
      b      <= r_ir[WIDTH-1:0];
    end
  end

  // Stage 3 ALU; results are truncated to WIDTH, unknown opcodes yield zero.
  always_comb begin
    w_alu = '0;
    case (opcode)
      OP_ADD:  w_alu = a + b;
      OP_SUB:  w_alu = a - b;
      OP_AND:  w_alu = a & b;
      OP_OR:   w_alu = a | b;
      OP_XOR:  w_alu = a ^ b;
      OP_NOT:  w_alu = ~a;
      OP_SHL:  w_alu = a << 1;
      OP_SHR:  w_alu = a >> 1;
      OP_INC:  w_alu = a + WIDTH'(1);
      OP_DEC:  w_alu = a - WIDTH'(1);
      OP_PASS: w_alu = a;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y <= '0;
    end else begin
      y <= w_alu;
    end
  end

endmodule

// File: tb/tb_pipeline_top.sv
// Directed bench for pipeline_top: preloads a 16-word program, checks decode and
// result latency, pc wrap, and asynchronous reset in the middle of execution.
module tb_pipeline_top;

  logic       clk;
  logic       reset;
  logic [7:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] y;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [23:0] word;
    logic [7:0]  exp_y;
  } vec_t;

  vec_t prog [16];

  pipeline_top #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) uut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .y      (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " opcode"}, 32'(opcode), 32'h0);
    check({tag, " a"},      32'(a),      32'h0);
    check({tag, " b"},      32'(b),      32'h0);
    check({tag, " y"},      32'(y),      32'h0);
    check({tag, " pc"},     32'(uut.r_pc), 32'h0);
  endtask

  task automatic check_decode(input string tag, input int idx);
    logic [23:0] w;
    w = prog[idx % 16].word;
    check($sformatf("%s opcode[%0d]", tag, idx), 32'(opcode), 32'(w[23:16]));
    check($sformatf("%s a[%0d]", tag, idx),      32'(a),      32'(w[15:8]));
    check($sformatf("%s b[%0d]", tag, idx),      32'(b),      32'(w[7:0]));
  endtask

  initial begin
    prog[0]  = '{24'h000305, 8'h08};  // ADD 3+5
    prog[1]  = '{24'h01050A, 8'hFB};  // SUB 5-10 borrow discarded
    prog[2]  = '{24'h00FF02, 8'h01};  // ADD carry discarded
    prog[3]  = '{24'h02F00F, 8'h00};  // AND
    prog[4]  = '{24'h03F00F, 8'hFF};  // OR
    prog[5]  = '{24'h04FF0F, 8'hF0};  // XOR
    prog[6]  = '{24'h058000, 8'h7F};  // NOT
    prog[7]  = '{24'h068100, 8'h02};  // SHL
    prog[8]  = '{24'h078100, 8'h40};  // SHR logical
    prog[9]  = '{24'h1F1234, 8'h00};  // undefined opcode
    prog[10] = '{24'h08FF00, 8'h00};  // INC wraps
    prog[11] = '{24'h090000, 8'hFF};  // DEC wraps
    prog[12] = '{24'h0A5A00, 8'h5A};  // PASS
    prog[13] = '{24'h06FF00, 8'hFE};  // SHL drops msb
    prog[14] = '{24'h02AA0F, 8'h0A};  // AND
    prog[15] = '{24'h0355AA, 8'hFF};  // OR

    for (int i = 0; i < 16; i++) uut.instr_mem[i] = prog[i].word;

    // Reset held across a clock edge
    reset = 1'b1;
    #3;
    check_zero("rst_pre_edge");
    #5;
    check_zero("rst_post_edge");
    #2;
    @(negedge clk);
    reset = 1'b0;

    // Edge 1: instruction 0 fetched, nothing decoded yet
    step();
    check("e1 opcode", 32'(opcode), 32'h0);
    check("e1 y", 32'(y), 32'h0);
    // Edge 2: instruction 0 decoded, y still from bubble
    step();
    check_decode("e2", 0);
    check("e2 y", 32'(y), 32'h0);

    // Edges 3..20: y for instruction e-3, decode for e-2; crosses the pc wrap
    for (int e = 3; e <= 20; e++) begin
      step();
      check($sformatf("y[%0d]", e - 3), 32'(y), 32'(prog[(e - 3) % 16].exp_y));
      check_decode("run", e - 2);
    end

    // Asynchronous reset a few ns after an edge, no clock edge needed
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    step();
    check_zero("async_rst_held");
    @(negedge clk);
    reset = 1'b0;

    step();
    check("restart e1 y", 32'(y), 32'h0);
    step();
    check_decode("restart e2", 0);
    check("restart e2 y", 32'(y), 32'h0);
    step();
    check("restart e3 y", 32'(y), 32'h08);
    check_decode("restart e3", 1);
    step();
    check("restart e4 y", 32'(y), 32'hFB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
